// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the programmable clock divider.
//   CNT_W     - width of divide ratio, high time and period counter
//   MIN_DIV   - smallest legal divide ratio
//   state_e   - controller states
//   cfg_t     - one divider configuration {div, high}
//   cfg_legal - legality check for an offered configuration
package clk_div_pkg;

  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } cfg_t;

  // Legal when div >= 2 and 1 <= high <= div-1 (high < div avoids the subtract).
  function automatic logic cfg_legal(input cfg_t c);
    return (c.div >= MIN_DIV) && (c.high != '0) && (c.high < c.div);
  endfunction

endpackage

// File: rtl/clk_div_period_cnt.sv
// clk_div_period_cnt: period counter that wraps from limit back to 0.
//   clk, rst_n - clock and synchronous active-low reset
//   clear      - force the counter to 0 next cycle (dominates enable)
//   enable     - advance the counter
//   limit      - last count value of the period (N-1)
//   cnt        - current count
//   wrap       - current count equals limit (last cycle of the period)
module clk_div_period_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == limit);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-reprogrammable clock divider controller.
//   clk, rst_n - clock and synchronous active-low reset
//   en         - run enable; low forces idle with outputs 0
//   cfg_valid  - configuration offered
//   cfg_div    - divide ratio N
//   cfg_high   - high cycles H
//   cfg_ready  - configuration can be accepted this cycle
//   cfg_err    - one-cycle pulse after an illegal configuration was consumed
//   div_out    - high for the first H of every N cycles
//   tick_out   - pulse on cycle 0 of each period
//   busy       - controller is in RUN or PEND
// New configurations accepted while running are held pending and promoted at
// the period boundary, so the waveform never changes mid-period.
module clk_div_ctrl
  import clk_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick_out,
  output logic             busy
);

  state_e state_q, state_d;
  cfg_t   act_q, act_d;
  cfg_t   pend_q, pend_d;
  logic   loaded_q, loaded_d;
  logic   ready_q, ready_d;
  logic   err_q, err_d;
  logic   div_q, div_d;
  logic   tick_q, tick_d;
  logic   busy_q, busy_d;

  cfg_t             cfg_in;
  logic             xfer;
  logic             legal_xfer;
  logic             run_d;
  logic             cnt_clear;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_wrap;

  assign cfg_in     = '{div: cfg_div, high: cfg_high};
  assign xfer       = cfg_valid && ready_q;
  assign legal_xfer = xfer && cfg_legal(cfg_in);

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    pend_d   = pend_q;
    loaded_d = loaded_q;

    unique case (state_q)
      IDLE: begin
        if (legal_xfer) begin
          act_d    = cfg_in;
          loaded_d = 1'b1;
        end
        // Uses the already-loaded flag, so a first config costs one idle cycle.
        if (en && loaded_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          if (legal_xfer) begin
            act_d = cfg_in;
          end
        end else if (legal_xfer) begin
          pend_d  = cfg_in;
          state_d = PEND;
        end
      end
      PEND: begin
        if (!en) begin
          state_d = IDLE;
          act_d   = pend_q;
        end else if (cnt_wrap) begin
          state_d = RUN;
          act_d   = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts from 0 when entering RUN and is held at 0 while idle.
  assign run_d     = (state_d != IDLE);
  assign cnt_clear = (state_q == IDLE) || !run_d;

  clk_div_period_cnt #(.W(CNT_W)) u_period_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (run_d),
    .limit  (act_q.div - CNT_W'(1)),
    .cnt    (cnt),
    .wrap   (cnt_wrap)
  );

  // Outputs are registered from next-cycle values so they line up with the
  // count the counter will hold, using the config that period will run on.
  assign cnt_nxt = (cnt_clear || cnt_wrap) ? '0 : cnt + CNT_W'(1);

  always_comb begin
    ready_d = (state_d != PEND);
    err_d   = xfer && !legal_xfer;
    div_d   = run_d && (cnt_nxt < act_d.high);
    tick_d  = run_d && (cnt_nxt == '0);
    busy_d  = run_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      act_q    <= '0;
      pend_q   <= '0;
      loaded_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      div_q    <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      loaded_q <= loaded_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign div_out   = div_q;
  assign tick_out  = tick_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed, table-driven bench for clk_div_ctrl.
// Each step drives one cycle of inputs, then compares the registered outputs
// seen after that clock edge, packed as {div_out, tick_out, cfg_ready,
// cfg_err, busy}.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       cfg_ready;
  logic       cfg_err;
  logic       div_out;
  logic       tick_out;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic       valid;
    logic [7:0] div;
    logic [7:0] high;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  clk_div_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .tick_out  (tick_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got {div,tick,rdy,err,busy}=%b required %b", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic r, input logic e, input logic v,
                      input logic [7:0] d, input logic [7:0] h, input logic [4:0] exp);
    rst_n     = r;
    en        = e;
    cfg_valid = v;
    cfg_div   = d;
    cfg_high  = h;
    @(posedge clk);
    #1;
    check(name, {div_out, tick_out, cfg_ready, cfg_err, busy}, exp);
  endtask

  task automatic add(input string name, input logic r, input logic e, input logic v,
                     input logic [7:0] d, input logic [7:0] h, input logic [4:0] exp);
    vec_t t;
    t.name = name; t.rst_n = r; t.en = e; t.valid = v;
    t.div = d; t.high = h; t.exp = exp;
    vecs.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;

    // Reset held with en/cfg_valid active: everything stays 0.
    add("rst0",        0, 1, 1, 8'd3, 8'd2, 5'b00000);
    add("rst1",        0, 1, 1, 8'd3, 8'd2, 5'b00000);
    add("rst2",        0, 1, 1, 8'd3, 8'd2, 5'b00000);
    // Release: valid ignored while ready is still low, ready rises next cycle.
    add("rel_ready",   1, 1, 1, 8'd3, 8'd2, 5'b00100);
    add("rel_noload",  1, 1, 0, 8'd0, 8'd0, 5'b00100);
    // Basic divide N=3 H=2: loaded-idle cycle, then 1,1,0 with tick on cnt 0.
    add("ld_3_2",      1, 1, 1, 8'd3, 8'd2, 5'b00100);
    add("b_c0",        1, 1, 0, 8'd0, 8'd0, 5'b11101);
    add("b_c1",        1, 1, 0, 8'd0, 8'd0, 5'b10101);
    add("b_c2",        1, 1, 0, 8'd0, 8'd0, 5'b00101);
    add("b_c0b",       1, 1, 0, 8'd0, 8'd0, 5'b11101);
    add("b_c1b",       1, 1, 0, 8'd0, 8'd0, 5'b10101);
    add("b_c2b",       1, 1, 0, 8'd0, 8'd0, 5'b00101);
    add("b_c0c",       1, 1, 0, 8'd0, 8'd0, 5'b11101);
    // en falls together with a legal transfer: config active, state IDLE.
    add("enfall_ld",   1, 0, 1, 8'd3, 8'd1, 5'b00100);
    add("r31_c0",      1, 1, 0, 8'd0, 8'd0, 5'b11101);
    add("r31_c1",      1, 1, 0, 8'd0, 8'd0, 5'b00101);
    add("r31_c2",      1, 1, 0, 8'd0, 8'd0, 5'b00101);
    // Illegal offers while running N=3 H=1: one err pulse each, waveform intact.
    add("ill_1_0",     1, 1, 1, 8'd1, 8'd0, 5'b11111);
    add("ill_gap1",    1, 1, 0, 8'd0, 8'd0, 5'b00101);
    add("ill_4_0",     1, 1, 1, 8'd4, 8'd0, 5'b00111);
    add("ill_gap2",    1, 1, 0, 8'd0, 8'd0, 5'b11101);
    add("ill_4_4",     1, 1, 1, 8'd4, 8'd4, 5'b00111);
    add("ill_gap3",    1, 1, 0, 8'd0, 8'd0, 5'b00101);
    add("ill_after",   1, 1, 0, 8'd0, 8'd0, 5'b11101);
    add("stop",        1, 0, 0, 8'd0, 8'd0, 5'b00100);

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].rst_n, vecs[i].en, vecs[i].valid,
           vecs[i].div, vecs[i].high, vecs[i].exp);
    end

    // Reconfig at boundary: N=4 H=1 running, N=5 H=3 offered at cnt=1.
    step("rc_ld",   1, 0, 1, 8'd4, 8'd1, 5'b00100);
    step("rc_c0",   1, 1, 0, 8'd0, 8'd0, 5'b11101);
    step("rc_c1",   1, 1, 0, 8'd0, 8'd0, 5'b00101);
    step("rc_p2",   1, 1, 1, 8'd5, 8'd3, 5'b00001);
    step("rc_p3",   1, 1, 0, 8'd0, 8'd0, 5'b00001);
    step("rc_n0",   1, 1, 0, 8'd0, 8'd0, 5'b11101);
    step("rc_n1",   1, 1, 0, 8'd0, 8'd0, 5'b10101);
    step("rc_n2",   1, 1, 0, 8'd0, 8'd0, 5'b10101);
    step("rc_n3",   1, 1, 0, 8'd0, 8'd0, 5'b00101);
    step("rc_n4",   1, 1, 0, 8'd0, 8'd0, 5'b00101);
    step("rc_n0b",  1, 1, 0, 8'd0, 8'd0, 5'b11101);

    // Enable toggle: N=6 H=3, en dropped at cnt=4, low for 5 edges.
    step("et_ld",   1, 0, 1, 8'd6, 8'd3, 5'b00100);
    step("et_c0",   1, 1, 0, 8'd0, 8'd0, 5'b11101);
    step("et_c1",   1, 1, 0, 8'd0, 8'd0, 5'b10101);
    step("et_c2",   1, 1, 0, 8'd0, 8'd0, 5'b10101);
    step("et_c3",   1, 1, 0, 8'd0, 8'd0, 5'b00101);
    step("et_c4",   1, 1, 0, 8'd0, 8'd0, 5'b00101);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("et_gap%0d", i), 1, 0, 0, 8'd0, 8'd0, 5'b00100);
    end
    step("et_r0",   1, 1, 0, 8'd0, 8'd0, 5'b11101);
    step("et_r1",   1, 1, 0, 8'd0, 8'd0, 5'b10101);

    // en dropped in PEND promotes the pending N=2 H=1 immediately.
    step("ep_pend", 1, 1, 1, 8'd2, 8'd1, 5'b10001);
    step("ep_idle", 1, 0, 0, 8'd0, 8'd0, 5'b00100);
    step("ep_c0",   1, 1, 0, 8'd0, 8'd0, 5'b11101);
    step("ep_c1",   1, 1, 0, 8'd0, 8'd0, 5'b00101);
    step("ep_c0b",  1, 1, 0, 8'd0, 8'd0, 5'b11101);

    // Reset in PEND clears everything; nothing runs until a new config.
    step("rp_pend", 1, 1, 1, 8'd7, 8'd2, 5'b00001);
    step("rp_rst",  0, 1, 0, 8'd0, 8'd0, 5'b00000);
    step("rp_rel",  1, 1, 0, 8'd0, 8'd0, 5'b00100);
    step("rp_hold", 1, 1, 0, 8'd0, 8'd0, 5'b00100);
    step("rp_hold2",1, 1, 0, 8'd0, 8'd0, 5'b00100);
    step("rp_ld",   1, 1, 1, 8'd3, 8'd2, 5'b00100);
    step("rp_c0",   1, 1, 0, 8'd0, 8'd0, 5'b11101);
    step("rp_c1",   1, 1, 0, 8'd0, 8'd0, 5'b10101);
    step("rp_c2",   1, 1, 0, 8'd0, 8'd0, 5'b00101);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
